mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 163 ++++++++++++++++
 tb/tb_mem_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of the pipeline: byte-addressable data memory built from
// 32-bit words, sized loads with sign/zero extension, lane-masked stores,
// misalignment detection with a sticky flag, and saturating access counters.
// Control and link fields pass straight through to the MEM/WB register.
module mem_stage #(
    parameter int PC_BITS        = 32,
    parameter int PROC_BITS      = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int MEM_ADDRS_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [PROC_BITS-1:0]      i_alu_data,
    input  logic [PROC_BITS-1:0]      i_write_data,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_RegWrite,
    input  logic                      i_MemtoReg,
    input  logic                      i_MemRead,
    input  logic                      i_MemWrite,
    input  logic [1:0]                i_mem_size,
    input  logic                      i_mem_unsigned,
    input  logic                      i_pc_to_reg,
    input  logic [PC_BITS-1:0]        i_pc_return,
    input  logic [MEM_ADDRS_BITS-1:0] i_dbg_addr,
    output logic [PROC_BITS-1:0]      o_dbg_data,
    output logic [PROC_BITS-1:0]      o_alu_data,
    output logic [REG_ADDRS_BITS-1:0] o_rd,
    output logic                      o_MemtoReg,
    output logic                      o_pc_to_reg,
    output logic [PC_BITS-1:0]        o_pc_return,
    output logic [PROC_BITS-1:0]      o_mem_data,
    output logic                      o_RegWrite,
    output logic                      o_misaligned,
    output logic [15:0]               o_load_count,
    output logic [15:0]               o_store_count
);

    localparam int MEM_WORDS = 1 << MEM_ADDRS_BITS;
    localparam int LANES     = PROC_BITS / 8;

    // Storage and sequential state
    logic [PROC_BITS-1:0] r_mem [MEM_WORDS];
    logic                 r_misaligned;
    logic [15:0]          r_load_count;
    logic [15:0]          r_store_count;

    // Address decode
    logic [MEM_ADDRS_BITS-1:0] w_addr;
    logic [1:0]                w_lane;
    logic                      w_is_half;
    logic                      w_is_word;
    logic                      w_misalign_addr;
    logic                      w_misaligned;
    logic                      w_load_en;
    logic                      w_store_en;

    // Data paths
    logic [PROC_BITS-1:0] w_rd_word;
    logic [7:0]           w_sel_byte;
    logic [15:0]          w_sel_half;
    logic [PROC_BITS-1:0] w_load_ext;
    logic [PROC_BITS-1:0] w_store_data;
    logic [LANES-1:0]     w_store_mask;

    // Address bits above the word index wrap around and are deliberately ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, i_alu_data[PROC_BITS-1:MEM_ADDRS_BITS+2]};

    assign w_addr    = i_alu_data[MEM_ADDRS_BITS+1:2];
    assign w_lane    = i_alu_data[1:0];
    assign w_is_half = (i_mem_size == 2'b01);
    assign w_is_word = i_mem_size[1];   // 10 and 11 both mean word

    // Bytes are always aligned; halves need an even address; words need addr[1:0]==0.
    assign w_misalign_addr = (w_is_half && w_lane[0]) || (w_is_word && (w_lane != 2'b00));
    assign w_misaligned    = (i_MemRead || i_MemWrite) && w_misalign_addr;
    assign w_load_en       = i_MemRead  && !w_misalign_addr;
    assign w_store_en      = i_MemWrite && !w_misalign_addr;

    // Asynchronous read: the word as it stood before the coming edge.
    assign w_rd_word  = r_mem[w_addr];
    assign w_sel_byte = w_rd_word[{w_lane, 3'b000} +: 8];
    assign w_sel_half = w_rd_word[{w_lane[1], 4'b0000} +: 16];

    // Select and extend the addressed byte/half/word for the load result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_load_ext = '0;
        case (i_mem_size)
            2'b00: w_load_ext = i_mem_unsigned ? {{(PROC_BITS-8){1'b0}}, w_sel_byte}
                                               : {{(PROC_BITS-8){w_sel_byte[7]}}, w_sel_byte};
            2'b01: w_load_ext = i_mem_unsigned ? {{(PROC_BITS-16){1'b0}}, w_sel_half}
                                               : {{(PROC_BITS-16){w_sel_half[15]}}, w_sel_half};
            default: w_load_ext = w_rd_word;
        endcase
    end

    // Replicate store data across lanes and build the byte-lane write mask.
    always_comb begin
        w_store_data = i_write_data;
        w_store_mask = '1;
        case (i_mem_size)
            2'b00: begin
                w_store_data = {LANES{i_write_data[7:0]}};
                w_store_mask = LANES'(1) << w_lane;
            end
            2'b01: begin
                w_store_data = {(LANES/2){i_write_data[15:0]}};
                w_store_mask = w_lane[1] ? LANES'(4'b1100) : LANES'(4'b0011);
            end
            default: begin
                w_store_data = i_write_data;
                w_store_mask = '1;
            end
        endcase
    end

    // Memory, sticky flag and counters: synchronous clear first, then gated by enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            // NOTE: the memory is cleared word by word on reset, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= '0;
            end
            r_misaligned  <= 1'b0;
            r_load_count  <= '0;
            r_store_count <= '0;
        end else if (enable) begin
            if (w_store_en) begin
                for (int k = 0; k < LANES; k++) begin
                    if (w_store_mask[k]) begin
                        r_mem[w_addr][8*k +: 8] <= w_store_data[8*k +: 8];
                    end
                end
            end
            if (w_misaligned) begin
                r_misaligned <= 1'b1;
            end
            if (w_load_en && (r_load_count != 16'hFFFF)) begin
                r_load_count <= r_load_count + 16'd1;
            end
            if (w_store_en && (r_store_count != 16'hFFFF)) begin
                r_store_count <= r_store_count + 16'd1;
            end
        end
    end

    assign o_mem_data    = w_load_en ? w_load_ext : '0;
    assign o_RegWrite    = i_RegWrite && !w_misaligned;
    assign o_misaligned  = r_misaligned;
    assign o_load_count  = r_load_count;
    assign o_store_count = r_store_count;
    assign o_dbg_data    = r_mem[i_dbg_addr];

    assign o_alu_data  = i_alu_data;
    assign o_rd        = i_rd;
    assign o_MemtoReg  = i_MemtoReg;
    assign o_pc_to_reg = i_pc_to_reg;
    assign o_pc_return = i_pc_return;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors plus randomized accesses
// compared against a byte-addressed reference model kept in the bench.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] i_alu_data;
    logic [31:0] i_write_data;
    logic [4:0]  i_rd;
    logic        i_RegWrite, i_MemtoReg, i_MemRead, i_MemWrite;
    logic [1:0]  i_mem_size;
    logic        i_mem_unsigned;
    logic        i_pc_to_reg;
    logic [31:0] i_pc_return;
    logic [9:0]  i_dbg_addr;
    logic [31:0] o_dbg_data, o_alu_data, o_mem_data, o_pc_return;
    logic [4:0]  o_rd;
    logic        o_MemtoReg, o_pc_to_reg, o_RegWrite, o_misaligned;
    logic [15:0] o_load_count, o_store_count;

    mem_stage dut (
        .clk(clk), .rst(rst), .enable(enable),
        .i_alu_data(i_alu_data), .i_write_data(i_write_data), .i_rd(i_rd),
        .i_RegWrite(i_RegWrite), .i_MemtoReg(i_MemtoReg), .i_MemRead(i_MemRead),
        .i_MemWrite(i_MemWrite), .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
        .i_pc_to_reg(i_pc_to_reg), .i_pc_return(i_pc_return), .i_dbg_addr(i_dbg_addr),
        .o_dbg_data(o_dbg_data), .o_alu_data(o_alu_data), .o_rd(o_rd),
        .o_MemtoReg(o_MemtoReg), .o_pc_to_reg(o_pc_to_reg), .o_pc_return(o_pc_return),
        .o_mem_data(o_mem_data), .o_RegWrite(o_RegWrite), .o_misaligned(o_misaligned),
        .o_load_count(o_load_count), .o_store_count(o_store_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 4 KiB of bytes, byte address taken modulo 4096.
    logic [7:0] m_mem [4096];
    bit         m_mis;
    int         m_ld, m_st;
    logic [31:0] obs_mem_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input bit uns);
        logic [31:0] v = 32'd0;
        int n = nbytes(size);
        for (int i = 0; i < n; i++) v |= 32'(m_mem[(addr + i) % 4096]) << (8 * i);
        if (n < 4 && !uns && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned w);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < 4; i++) v |= 32'(m_mem[(4 * w + i) % 4096]) << (8 * i);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        for (int i = 0; i < nbytes(size); i++) m_mem[(addr + i) % 4096] = 8'(data >> (8 * i));
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) m_mem[i] = 8'd0;
        m_mis = 0; m_ld = 0; m_st = 0;
    endtask

    // One pipeline cycle: check combinational results before the edge, state after it.
    task automatic do_access(input bit rd_en, input bit wr_en, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] data, input bit en, input bit regwr);
        logic [31:0] exp_data, pc_v;
        logic [4:0]  rd_v;
        logic [9:0]  dbg_v;
        bit mis_addr, mis, m2r_v, p2r_v;
        @(negedge clk);
        rd_v = 5'($urandom); pc_v = $urandom; m2r_v = 1'($urandom); p2r_v = 1'($urandom);
        dbg_v = 10'($urandom);
        enable = en; i_MemRead = rd_en; i_MemWrite = wr_en; i_mem_size = size;
        i_mem_unsigned = uns; i_alu_data = addr; i_write_data = data; i_RegWrite = regwr;
        i_rd = rd_v; i_pc_return = pc_v; i_MemtoReg = m2r_v; i_pc_to_reg = p2r_v; i_dbg_addr = dbg_v;
        mis_addr = model_misaligned(addr, size);
        mis = (rd_en || wr_en) && mis_addr;
        exp_data = (rd_en && !mis_addr) ? model_load(addr, size, uns) : 32'd0;
        #1;
        obs_mem_data = o_mem_data;
        check("mem_data", o_mem_data, exp_data);
        check("regwrite", 32'(o_RegWrite), 32'(regwr && !mis));
        check("alu_pass", o_alu_data, addr);
        check("pass_fields", {o_rd, o_MemtoReg, o_pc_to_reg}, {rd_v, m2r_v, p2r_v});
        check("pc_pass", o_pc_return, pc_v);
        check("dbg_pre", o_dbg_data, model_word(dbg_v));
        @(posedge clk);
        if (en) begin
            if (wr_en && !mis_addr) begin
                model_store(addr, size, data);
                if (m_st < 65535) m_st++;
            end
            if (rd_en && !mis_addr && m_ld < 65535) m_ld++;
            if (mis) m_mis = 1;
        end
        #1;
        check("load_count", 32'(o_load_count), 32'(m_ld));
        check("store_count", 32'(o_store_count), 32'(m_st));
        check("misaligned", 32'(o_misaligned), 32'(m_mis));
        i_dbg_addr = addr[11:2];
        #1;
        check("dbg_post", o_dbg_data, model_word(addr[11:2]));
    endtask

    // Reset for one edge while a store is presented, to show reset wins.
    task automatic apply_reset(input bit en);
        @(negedge clk);
        rst = 1'b0; enable = en; i_MemWrite = 1'b1; i_MemRead = 1'b0;
        i_mem_size = 2'b10; i_alu_data = 32'h0000_0008; i_write_data = 32'h5A5A_5A5A;
        @(posedge clk);
        model_clear();
        #1;
        check("rst_load_count", 32'(o_load_count), 32'd0);
        check("rst_store_count", 32'(o_store_count), 32'd0);
        check("rst_misaligned", 32'(o_misaligned), 32'd0);
        i_dbg_addr = 10'd2;
        #1;
        check("rst_no_store", o_dbg_data, 32'd0);
        @(negedge clk);
        rst = 1'b1; i_MemWrite = 1'b0;
    endtask

    initial begin
        logic [31:0] addr, saved;
        int ld0, st0;
        rst = 1'b0; enable = 1'b1; i_alu_data = '0; i_write_data = '0; i_rd = '0;
        i_RegWrite = 0; i_MemtoReg = 0; i_MemRead = 0; i_MemWrite = 0; i_mem_size = 0;
        i_mem_unsigned = 0; i_pc_to_reg = 0; i_pc_return = '0; i_dbg_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        apply_reset(1'b1);

        // Word store then word load at 0x8.
        do_access(0, 1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF, 1, 0);
        do_access(1, 0, 2'b10, 0, 32'h8, 32'h0, 1, 1);
        check("v34_data", obs_mem_data, 32'hDEAD_BEEF);
        check("v34_counts", {o_store_count, o_load_count}, 32'h0001_0001);

        // Byte store into a zero word, then signed/unsigned byte and word loads.
        do_access(0, 1, 2'b00, 0, 32'h11, 32'hABCD_EF80, 1, 0);
        do_access(1, 0, 2'b00, 0, 32'h11, 32'h0, 1, 1);
        check("v35_signed", obs_mem_data, 32'hFFFF_FF80);
        do_access(1, 0, 2'b00, 1, 32'h11, 32'h0, 1, 1);
        check("v35_unsigned", obs_mem_data, 32'h0000_0080);
        do_access(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 1);
        check("v35_word", obs_mem_data, 32'h0000_8000);

        // Address wrap: 0x1000 aliases word 0.
        do_access(0, 1, 2'b10, 0, 32'h1000, 32'h1234_5678, 1, 0);
        i_dbg_addr = 10'd0; #1;
        check("v39_wrap", o_dbg_data, 32'h1234_5678);

        // Disabled store leaves everything alone; enabling commits it.
        st0 = m_st;
        do_access(0, 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 0, 0);
        check("v37_frozen_mem", o_dbg_data, 32'h0);
        check("v37_frozen_cnt", 32'(o_store_count), 32'(st0));
        do_access(0, 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 1, 0);
        check("v37_commit", o_dbg_data, 32'hCAFE_F00D);

        // Misaligned half load and word store.
        ld0 = m_ld; st0 = m_st;
        saved = model_word(0);
        do_access(1, 0, 2'b01, 0, 32'h3, 32'h0, 1, 1);
        check("v36_data", obs_mem_data, 32'h0);
        check("v36_flag", 32'(o_misaligned), 32'd1);
        do_access(0, 1, 2'b10, 0, 32'h2, 32'hFFFF_FFFF, 1, 1);
        check("v36_mem", o_dbg_data, saved);
        check("v36_counts", {o_store_count, o_load_count}, {16'(st0), 16'(ld0)});

        // Randomized traffic on a small window, sometimes with high alias bits.
        apply_reset(1'b1);
        for (int n = 0; n < 400; n++) begin
            addr = $urandom_range(0, 63);
            if ($urandom_range(0, 3) == 0) addr |= ($urandom & 32'hFFFF_F000);
            do_access(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
                      $urandom_range(0, 7) != 0, 1'($urandom));
        end

        // Saturate the store counter, then one more store must hold it at 0xFFFF.
        apply_reset(1'b1);
        @(negedge clk);
        enable = 1; i_MemWrite = 1; i_MemRead = 0; i_mem_size = 2'b10;
        i_alu_data = 32'h40; i_write_data = 32'h0BAD_F00D;
        repeat (65535) @(posedge clk);
        model_store(32'h40, 2'b10, 32'h0BAD_F00D);
        m_st = 65535;
        #1;
        check("sat_reach", 32'(o_store_count), 32'h0000_FFFF);
        do_access(0, 1, 2'b00, 0, 32'h41, 32'h77, 1, 0);
        check("sat_hold", 32'(o_store_count), 32'h0000_FFFF);

        // Reset with enable low still clears everything; sweep the whole memory.
        apply_reset(1'b0);
        for (int w = 0; w < 1024; w++) begin
            i_dbg_addr = 10'(w);
            #1;
            check("sweep_zero", o_dbg_data, model_word(w));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
